residual_debinarize: RTL and testbench

//   Sequential decoder for the multi-level residual binarizer. Takes one pixel's LEVELS-bit

---
 rtl/residual_debinarize.sv | 117 +++++++++++
 tb/tb_residual_debinarize.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/residual_debinarize.sv
// Sequential residual-code decoder: rebuilds sum_i(+/-gamma[i]) one level per cycle,
// then saturates the result to TWIDTH and holds it on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a code; in_ready high
// ACCUM | adding/subtracting one gamma per cycle
// DONE  | result presented, held until out_ready
module residual_debinarize #(
  parameter int TWIDTH    = 24,
  parameter int LEVELS    = 2,
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEVELS-1:0]        in_bits,
  input  logic [TWIDTH*LEVELS-1:0] gamma,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TWIDTH-1:0]        out_value,
  output logic                     out_sat
);

  localparam int AW = TWIDTH + $clog2(LEVELS) + 1;
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [LW-1:0] LAST = LW'(LEVELS - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-TWIDTH+1){1'b0}}, {(TWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-TWIDTH+1){1'b1}}, {(TWIDTH-1){1'b0}}};

  // FRAC_BITS only names the fixed-point format; reject nonsensical settings at elaboration.
  if (LEVELS < 1 || FRAC_BITS < 0 || FRAC_BITS >= TWIDTH) begin : g_bad_param
    $error("residual_debinarize: illegal LEVELS/FRAC_BITS setting");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state, state_nxt;
  logic [LEVELS-1:0]         bits_reg;
  logic [TWIDTH*LEVELS-1:0]  gamma_reg;
  logic signed [AW-1:0]      acc, acc_nxt, term;
  logic [TWIDTH-1:0]         g_cur;
  logic [LW-1:0]             level;
  logic                      sat_hi, sat_lo;
  logic [TWIDTH-1:0]         clamp_value;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ACCUM;
      ACCUM:   if (level == LAST) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gammas are sign-extended into the wider accumulator, so partial sums never wrap.
  always_comb begin
    g_cur   = gamma_reg[int'(level)*TWIDTH +: TWIDTH];
    term    = {{(AW-TWIDTH){g_cur[TWIDTH-1]}}, g_cur};
    acc_nxt = bits_reg[level] ? (acc + term) : (acc - term);
  end

  always_comb begin
    sat_hi      = (acc > MAXV);
    sat_lo      = (acc < MINV);
    clamp_value = acc[TWIDTH-1:0];
    if (sat_hi)      clamp_value = {1'b0, {(TWIDTH-1){1'b1}}};
    else if (sat_lo) clamp_value = {1'b1, {(TWIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_reg  <= '0;
      gamma_reg <= '0;
      acc       <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bits_reg  <= in_bits;
            gamma_reg <= gamma;
            acc       <= '0;
            level     <= '0;
          end
        end
        ACCUM: begin
          acc   <= acc_nxt;
          level <= level + LW'(1);
        end
        DONE: begin
          // First DONE cycle latches the clamped sum; output then stays put until taken.
          if (!out_valid) begin
            out_value <= clamp_value;
            out_sat   <= sat_hi | sat_lo;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_residual_debinarize.sv
// Self-checking bench for residual_debinarize (TWIDTH=24, LEVELS=2) against an
// arithmetic reference model and a behavioural residual binarizer.
module tb_residual_debinarize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_bits;
  logic [47:0] gamma;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_value;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  residual_debinarize #(.TWIDTH(24), .LEVELS(2), .FRAC_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .gamma(gamma), .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Unclamped sum of +/-gamma per level, in plain integer arithmetic.
  function automatic longint ref_sum(input logic [1:0] b, input logic [23:0] g0, input logic [23:0] g1);
    longint g[2];
    longint s;
    g[0] = longint'($signed(g0));
    g[1] = longint'($signed(g1));
    s = 0;
    for (int i = 0; i < 2; i++) s += b[i] ? g[i] : -g[i];
    return s;
  endfunction

  function automatic longint clamp24(input longint s);
    if (s > 64'sd8388607) return 64'sd8388607;
    if (s < -64'sd8388608) return -64'sd8388608;
    return s;
  endfunction

  // Greedy residual binarizer: each level's sign follows the remaining residual.
  function automatic logic [1:0] binarize(input longint x, input logic [23:0] g0, input logic [23:0] g1);
    longint r;
    longint g[2];
    logic [1:0] b;
    g[0] = longint'($signed(g0));
    g[1] = longint'($signed(g1));
    r = x;
    for (int i = 0; i < 2; i++) begin
      b[i] = (r >= 0);
      r = b[i] ? r - g[i] : r + g[i];
    end
    return b;
  endfunction

  // Stimulus only: pushes one pixel with out_ready high and reports what came back.
  task automatic run_pixel(input logic [1:0] b, input logic [23:0] g0, input logic [23:0] g1,
                           output logic [23:0] val, output logic sat, output int lat,
                           output bit timeout);
    int n;
    timeout = 0;
    n = 0;
    out_ready = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout = 1;
    in_valid = 1'b1;
    in_bits  = b;
    gamma    = {g1, g0};
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bits  = 2'($urandom);
    gamma    = {24'($urandom), 24'($urandom)};
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) timeout = 1;
    val = out_value;
    sat = out_sat;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bits = '0;
    gamma = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_value !== 24'h0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_output out_value=%h out_sat=%b required 000000/0", out_value, out_sat);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [1:0]  pats[4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic [23:0] v;
    logic        s;
    int          lat;
    bit          to;
    logic [23:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      run_pixel(pats[i], 24'h000200, 24'h000080, v, s, lat, to);
      exp_v = 24'(clamp24(ref_sum(pats[i], 24'h000200, 24'h000080)));
      checks++;
      if (to) begin
        errors++;
        $display("FAIL basic_timeout bits=%b no result within bound", pats[i]);
      end
      checks++;
      if (v !== exp_v || s !== 1'b0) begin
        errors++;
        $display("FAIL basic_value bits=%b got %h sat=%b required %h sat=0", pats[i], v, s, exp_v);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL basic_latency bits=%b got %0d edges required 3", pats[i], lat);
      end
    end
  endtask

  task automatic test_saturation;
    logic [23:0] v;
    logic        s;
    int          lat;
    bit          to;
    run_pixel(2'b11, 24'h7FFFFF, 24'h7FFFFF, v, s, lat, to);
    checks++;
    if (to || v !== 24'h7FFFFF || s !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos got %h sat=%b timeout=%0d required 7fffff sat=1", v, s, to);
    end
    run_pixel(2'b00, 24'h7FFFFF, 24'h7FFFFF, v, s, lat, to);
    checks++;
    if (to || v !== 24'h800000 || s !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg got %h sat=%b timeout=%0d required 800000 sat=1", v, s, to);
    end
    // Exactly at the negative limit is not a clamp.
    run_pixel(2'b00, 24'h400000, 24'h400000, v, s, lat, to);
    checks++;
    if (to || v !== 24'h800000 || s !== 1'b0) begin
      errors++;
      $display("FAIL sat_edge got %h sat=%b timeout=%0d required 800000 sat=0", v, s, to);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [23:0] held;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_bits  = 2'b01;
    gamma    = {24'h000080, 24'h000200};
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_value !== 24'h000180) begin
      errors++;
      $display("FAIL bp_result out_valid=%b out_value=%h required 1/000180", out_valid, out_value);
    end
    held = 24'h000180;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bits  = 2'($urandom);
      gamma    = {24'($urandom), 24'($urandom)};
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_value !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d out_valid=%b out_value=%h in_ready=%b required 1/%h/0",
                 i, out_valid, out_value, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignored_pulses out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [23:0] v;
    logic        s;
    int          lat;
    bit          to;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bits  = 2'b00;
    gamma    = {24'h000080, 24'h000200};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_value !== 24'h0) begin
      errors++;
      $display("FAIL rst_mid out_valid=%b in_ready=%b out_value=%h required 0/1/000000",
               out_valid, in_ready, out_value);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort out_valid=%b required 0", out_valid);
    end
    run_pixel(2'b11, 24'h000200, 24'h000080, v, s, lat, to);
    checks++;
    if (to || v !== 24'h000280 || s !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover got %h sat=%b timeout=%0d required 000280 sat=0", v, s, to);
    end
  endtask

  task automatic test_roundtrip;
    logic [23:0] g0, g1, v, exp_v;
    logic [1:0]  b;
    logic        s, exp_s;
    longint      x, sum;
    int          lat;
    bit          to;
    int          bad;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k % 4 == 3) begin
        g0 = 24'($urandom);
        g1 = 24'($urandom);
        b  = 2'($urandom);
      end else begin
        g0 = 24'($urandom_range(32'h7FFFFF, 1));
        g1 = 24'($urandom_range(32'(g0), 0));
        x  = longint'($urandom_range(32'h1FFFFFF, 0)) - 64'sd16777216;
        b  = binarize(x, g0, g1);
      end
      sum   = ref_sum(b, g0, g1);
      exp_v = 24'(clamp24(sum));
      exp_s = (clamp24(sum) != sum);
      run_pixel(b, g0, g1, v, s, lat, to);
      checks++;
      if (to || v !== exp_v || s !== exp_s || lat !== 3) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL roundtrip #%0d bits=%b g0=%h g1=%h got %h sat=%b lat=%0d required %h sat=%b lat=3",
                   k, b, g0, g1, v, s, lat, exp_v, exp_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
